// File: rtl/uart_bus_bridge.sv
// UART bus bridge: memory-mapped TXD/RXD/CON registers, TX FIFO with send
// sequencer, RX holding register and a level interrupt.
module uart_bus_bridge #(
  parameter logic [31:0] BASE_ADDR    = 32'h40000018,
  parameter int unsigned TXQ_DEPTH    = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_wr,
  input  logic        mem_rd,
  output logic [31:0] rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_status,
  input  logic        tx_status,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        irq
);

  localparam int unsigned AW = $clog2(TXQ_DEPTH);
  localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [AW:0]   PTR_ONE  = 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);
  localparam logic [31:0]   TXD_ADDR = BASE_ADDR;
  localparam logic [31:0]   RXD_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0]   CON_ADDR = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_t;

  tx_state_t     state;
  logic [7:0]    txq [TXQ_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] busy_cnt;
  logic [7:0]    rx_buf;
  logic          rx_valid;
  logic          rx_ovf;
  logic          tx_ovf;
  logic          tx_irq_en;
  logic          rx_irq_en;
  logic          sel_txd;
  logic          sel_rxd;
  logic          sel_con;
  logic          txd_wr;
  logic          rxd_rd;
  logic          con_wr;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          tx_drop;
  logic          tx_idle;
  logic          unused_wdata;

  assign sel_txd = (addr == TXD_ADDR);
  assign sel_rxd = (addr == RXD_ADDR);
  assign sel_con = (addr == CON_ADDR);
  assign txd_wr  = mem_wr && sel_txd;
  assign rxd_rd  = mem_rd && sel_rxd;
  assign con_wr  = mem_wr && sel_con;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
  assign pop     = (state == IDLE) && !fifo_empty && tx_status;
  assign push    = txd_wr && (!fifo_full || pop);
  assign tx_drop = txd_wr && fifo_full && !pop;

  assign tx_idle = fifo_empty && (state == IDLE);
  assign irq     = (tx_irq_en && tx_idle) || (rx_irq_en && rx_valid);

  assign unused_wdata = ^{wdata[31:8], wdata[4:2]};

  always_comb begin
    rdata = '0;
    if (sel_rxd) begin
      rdata = {24'h0, rx_buf};
    end else if (sel_con) begin
      rdata = {25'h0, tx_ovf, rx_ovf, fifo_full, tx_idle, rx_valid, rx_irq_en, tx_irq_en};
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) begin
      txq[wr_ptr[AW-1:0]] <= wdata[7:0];
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx_data  <= '0;
      tx_en    <= 1'b0;
      busy_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= txq[rd_ptr[AW-1:0]];
            tx_en   <= 1'b1;
            state   <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_en    <= 1'b0;
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_status) begin
            state <= WAIT_DONE;
          end else if (busy_cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            busy_cnt <= busy_cnt + CNT_ONE;
          end
        end
        WAIT_DONE: begin
          if (tx_status) state <= IDLE;
        end
        default: begin
          tx_en <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      rx_buf   <= '0;
      rx_valid <= 1'b0;
      rx_ovf   <= 1'b0;
    end else begin
      if (rx_status) begin
        rx_buf   <= rx_data;
        rx_valid <= 1'b1;
      end else if (rxd_rd) begin
        rx_valid <= 1'b0;
      end
      if (rx_status && rx_valid && !rxd_rd) begin
        rx_ovf <= 1'b1;
      end else if (con_wr && wdata[5]) begin
        rx_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      tx_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_ovf    <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_irq_en <= wdata[0];
        rx_irq_en <= wdata[1];
      end
      if (tx_drop) begin
        tx_ovf <= 1'b1;
      end else if (con_wr && wdata[6]) begin
        tx_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
module tb_uart_bus_bridge;

  localparam logic [31:0] BASE = 32'h40000018;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] RXD  = BASE + 32'd4;
  localparam logic [31:0] CON  = BASE + 32'd8;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_wr = 1'b0;
  logic        mem_rd = 1'b0;
  logic [31:0] rdata;
  logic [7:0]  rx_data = '0;
  logic        rx_status = 1'b0;
  logic        tx_status;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        irq;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  uart_bus_bridge #(.BASE_ADDR(BASE), .TXQ_DEPTH(4), .BUSY_TIMEOUT(TMO)) dut (
    .sysclk(clk), .rst(rst), .addr(addr), .wdata(wdata), .mem_wr(mem_wr),
    .mem_rd(mem_rd), .rdata(rdata), .rx_data(rx_data), .rx_status(rx_status),
    .tx_status(tx_status), .tx_data(tx_data), .tx_en(tx_en), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART sender model. mode 0: busy for a random while after each tx_en;
  // mode 1: never goes busy; mode 3: goes busy and stays busy until mode changes.
  int         mode = 0;
  logic       force_busy = 1'b0;
  logic [7:0] sent_q[$];
  int         en_cyc_q[$];
  int         en_cnt = 0;
  int         width_err = 0;
  int         hold_err = 0;
  logic       model_active = 1'b0;

  initial begin : uart_model
    logic       prev_en;
    logic       low;
    logic [7:0] cur;
    int         pre;
    int         busy;
    prev_en = 1'b0; low = 1'b0; cur = '0; pre = 0; busy = 0;
    tx_status = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_en === 1'b1) begin
        if (prev_en) begin
          width_err++;
        end else begin
          en_cnt++;
          sent_q.push_back(tx_data);
          en_cyc_q.push_back(cyc);
          if (mode == 0) begin
            cur = tx_data;
            pre = $urandom_range(0, 3);
            busy = $urandom_range(2, 5);
            model_active = 1'b1;
          end else if (mode == 3) begin
            low = 1'b1;
          end
        end
      end
      prev_en = (tx_en === 1'b1);
      if (model_active) begin
        if (tx_data !== cur) hold_err++;
        if (pre > 0) begin
          pre--;
        end else if (busy > 0) begin
          low = 1'b1;
          busy--;
        end else begin
          low = 1'b0;
          model_active = 1'b0;
        end
      end else if (mode != 3) begin
        low = 1'b0;
      end
      tx_status = !(low || force_busy);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_wr = 1'b1;
    @(negedge clk);
    mem_wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; mem_rd = 1'b1;
    #1 d = rdata;
    @(negedge clk);
    mem_rd = 1'b0; addr = '0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_data = d; rx_status = 1'b1;
    @(negedge clk);
    rx_status = 1'b0;
  endtask

  task automatic wait_tx_idle(output bit ok);
    logic [31:0] v;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      bus_read(CON, v);
      if (v[3] && !model_active && tx_status) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] unmapped [3];
    unmapped[0] = BASE + 32'd12; unmapped[1] = BASE - 32'd4; unmapped[2] = BASE + 32'd1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++; if (tx_en !== 1'b0) begin fails++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
    tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irq); end
    bus_read(CON, v);
    tests++; if (v !== 32'h8) begin fails++; $display("FAIL reset_con: got %h expected 00000008", v); end
    bus_read(RXD, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL reset_rxd: got %h expected 0", v); end
    bus_read(TXD, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL txd_read: got %h expected 0", v); end
    for (int i = 0; i < 3; i++) begin
      bus_read(unmapped[i], v);
      tests++; if (v !== 32'h0) begin fails++; $display("FAIL unmapped_read %h: got %h expected 0", unmapped[i], v); end
      bus_write(unmapped[i], 32'hFFFF_FFFF);
    end
    bus_read(CON, v);
    tests++; if (v !== 32'h8 || irq !== 1'b0 || en_cnt != 0) begin
      fails++; $display("FAIL unmapped_write: con %h irq %b launches %0d expected 00000008 0 0", v, irq, en_cnt);
    end
  endtask

  task automatic test_single_tx();
    int b;
    bit ok;
    mode = 0;
    b = sent_q.size();
    bus_write(TXD, 32'hFFFF_FF41);
    tests++; if (tx_en !== 1'b0) begin fails++; $display("FAIL single_early: tx_en %b expected 0", tx_en); end
    @(negedge clk);
    tests++; if (tx_en !== 1'b1 || tx_data !== 8'h41) begin
      fails++; $display("FAIL single_launch: tx_en %b data %h expected 1 41", tx_en, tx_data);
    end
    @(negedge clk);
    tests++; if (tx_en !== 1'b0) begin fails++; $display("FAIL single_pulse_width: tx_en %b expected 0", tx_en); end
    wait_tx_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_drain: got busy expected idle"); end
    tests++; if (sent_q.size() != b + 1 || sent_q[b] !== 8'h41 || hold_err != 0) begin
      fails++; $display("FAIL single_sent: count %0d byte %h hold_err %0d expected 1 41 0", sent_q.size() - b, sent_q[b], hold_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp_q[$];
    logic [31:0] v;
    int b;
    bit ok;
    mode = 0;
    b = sent_q.size();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      for (int k = 0; k < 100; k++) begin
        bus_read(CON, v);
        if (!v[4]) break;
      end
      bus_write(TXD, {24'h0, d});
      exp_q.push_back(d);
    end
    wait_tx_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_drain: got busy expected idle"); end
    tests++; if (sent_q.size() != b + exp_q.size()) begin
      fails++; $display("FAIL b2b_count: got %0d expected %0d", sent_q.size() - b, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++; if (sent_q[b + i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_byte[%0d]: got %h expected %h", i, sent_q[b + i], exp_q[i]);
      end
    end
    bus_read(CON, v);
    tests++; if (v[6] !== 1'b0 || hold_err != 0 || width_err != 0) begin
      fails++; $display("FAIL b2b_flags: tx_ovf %b hold_err %0d width_err %0d expected 0 0 0", v[6], hold_err, width_err);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    int b;
    int n;
    bit ok;
    mode = 0;
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    b = sent_q.size();
    n = en_cnt;
    for (int i = 1; i <= 5; i++) bus_write(TXD, i);
    bus_read(CON, v);
    tests++; if (v[6] !== 1'b1 || v[4] !== 1'b1 || v[3] !== 1'b0 || en_cnt != n) begin
      fails++; $display("FAIL ovf_set: tx_ovf %b full %b idle %b launches %0d expected 1 1 0 0", v[6], v[4], v[3], en_cnt - n);
    end
    force_busy = 1'b0;
    wait_tx_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovf_drain: got busy expected idle"); end
    tests++; if (sent_q.size() != b + 4) begin fails++; $display("FAIL ovf_count: got %0d expected 4", sent_q.size() - b); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (sent_q[b + i] !== 8'(i + 1)) begin
        fails++; $display("FAIL ovf_byte[%0d]: got %h expected %h", i, sent_q[b + i], 8'(i + 1));
      end
    end
    bus_write(CON, 32'h40);
    bus_read(CON, v);
    tests++; if (v !== 32'h8) begin fails++; $display("FAIL ovf_w1c: got %h expected 00000008", v); end
  endtask

  task automatic test_tx_irq();
    bit ok;
    int b;
    mode = 0;
    b = sent_q.size();
    bus_write(CON, 32'h1);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL tx_irq_idle: got %b expected 1", irq); end
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    bus_write(TXD, 32'h99);
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL tx_irq_busy: got %b expected 0", irq); end
    force_busy = 1'b0;
    wait_tx_idle(ok);
    tests++; if (!ok || irq !== 1'b1 || sent_q.size() != b + 1 || sent_q[b] !== 8'h99) begin
      fails++; $display("FAIL tx_irq_done: idle %b irq %b byte %h expected 1 1 99", ok, irq, sent_q[b]);
    end
    bus_write(CON, 32'h0);
  endtask

  task automatic test_rx_basic();
    logic [31:0] v;
    bus_write(CON, 32'h2);
    rx_pulse(8'h5A);
    tests++; if (irq !== 1'b1) begin fails++; $display("FAIL rx_irq_set: got %b expected 1", irq); end
    bus_read(CON, v);
    tests++; if (v[2] !== 1'b1) begin fails++; $display("FAIL rx_valid_set: got %b expected 1", v[2]); end
    bus_read(RXD, v);
    tests++; if (v !== 32'h5A) begin fails++; $display("FAIL rx_read: got %h expected 0000005a", v); end
    tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rx_irq_clear: got %b expected 0", irq); end
    bus_read(CON, v);
    tests++; if (v !== 32'h0A) begin fails++; $display("FAIL rx_con_after_read: got %h expected 0000000a", v); end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] v;
    bus_write(CON, 32'h0);
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    bus_read(CON, v);
    tests++; if (v[5] !== 1'b1 || v[2] !== 1'b1) begin
      fails++; $display("FAIL rx_ovf_set: ovf %b valid %b expected 1 1", v[5], v[2]);
    end
    bus_read(RXD, v);
    tests++; if (v !== 32'h22) begin fails++; $display("FAIL rx_ovf_data: got %h expected 00000022", v); end
    bus_write(CON, 32'h20);
    rx_pulse(8'h33);
    addr = RXD; mem_rd = 1'b1; rx_data = 8'h44; rx_status = 1'b1;
    #1 v = rdata;
    @(negedge clk);
    mem_rd = 1'b0; rx_status = 1'b0; addr = '0;
    tests++; if (v !== 32'h33) begin fails++; $display("FAIL rx_coincident_old: got %h expected 00000033", v); end
    bus_read(CON, v);
    tests++; if (v[5] !== 1'b0 || v[2] !== 1'b1) begin
      fails++; $display("FAIL rx_coincident_flags: ovf %b valid %b expected 0 1", v[5], v[2]);
    end
    bus_read(RXD, v);
    tests++; if (v !== 32'h44) begin fails++; $display("FAIL rx_coincident_new: got %h expected 00000044", v); end
    rx_pulse(8'h55);
    addr = CON; wdata = 32'h20; mem_wr = 1'b1; rx_data = 8'h66; rx_status = 1'b1;
    @(negedge clk);
    mem_wr = 1'b0; rx_status = 1'b0; addr = '0; wdata = '0;
    bus_read(CON, v);
    tests++; if (v[5] !== 1'b1) begin fails++; $display("FAIL rx_set_beats_w1c: got %b expected 1", v[5]); end
    bus_read(RXD, v);
    tests++; if (v !== 32'h66) begin fails++; $display("FAIL rx_set_beats_w1c_data: got %h expected 00000066", v); end
  endtask

  task automatic test_rx_random();
    logic [31:0] v;
    logic [7:0]  exp_buf;
    logic        exp_valid;
    logic        exp_ovf;
    bus_write(CON, 32'h22);
    exp_buf = 8'($urandom);
    rx_pulse(exp_buf);
    exp_valid = 1'b1;
    exp_ovf = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d;
      int op;
      d = 8'($urandom);
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          rx_pulse(d);
          if (exp_valid) exp_ovf = 1'b1;
          exp_buf = d; exp_valid = 1'b1;
        end
        1: begin
          bus_read(RXD, v);
          tests++; if (v !== {24'h0, exp_buf}) begin fails++; $display("FAIL rx_rand_read[%0d]: got %h expected %h", i, v, exp_buf); end
          exp_valid = 1'b0;
        end
        2: begin
          addr = RXD; mem_rd = 1'b1; rx_data = d; rx_status = 1'b1;
          #1 v = rdata;
          @(negedge clk);
          mem_rd = 1'b0; rx_status = 1'b0; addr = '0;
          tests++; if (v !== {24'h0, exp_buf}) begin fails++; $display("FAIL rx_rand_coinc[%0d]: got %h expected %h", i, v, exp_buf); end
          exp_buf = d; exp_valid = 1'b1;
        end
        3: begin
          bus_write(CON, 32'h22);
          exp_ovf = 1'b0;
        end
        default: @(negedge clk);
      endcase
      bus_read(CON, v);
      tests++; if (v[5] !== exp_ovf || v[2] !== exp_valid || irq !== exp_valid) begin
        fails++; $display("FAIL rx_rand_flags[%0d]: ovf %b valid %b irq %b expected %b %b %b", i, v[5], v[2], irq, exp_ovf, exp_valid, exp_valid);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] a;
    logic [7:0] c;
    int b;
    int n;
    bit ok;
    mode = 1;
    a = 8'($urandom);
    c = 8'($urandom);
    b = sent_q.size();
    n = en_cnt;
    bus_write(TXD, {24'h0, a});
    bus_write(TXD, {24'h0, c});
    for (int i = 0; i < 100 && en_cnt < n + 2; i++) @(negedge clk);
    tests++; if (en_cnt != n + 2) begin fails++; $display("FAIL timeout_relaunch: got %0d launches expected 2", en_cnt - n); end
    tests++; if (en_cyc_q[b + 1] - en_cyc_q[b] != TMO + 2) begin
      fails++; $display("FAIL timeout_gap: got %0d cycles expected %0d", en_cyc_q[b + 1] - en_cyc_q[b], TMO + 2);
    end
    tests++; if (sent_q[b] !== a || sent_q[b + 1] !== c) begin
      fails++; $display("FAIL timeout_bytes: got %h %h expected %h %h", sent_q[b], sent_q[b + 1], a, c);
    end
    wait_tx_idle(ok);
    tests++; if (!ok || width_err != 0) begin fails++; $display("FAIL timeout_idle: idle %b width_err %0d expected 1 0", ok, width_err); end
    mode = 0;
  endtask

  task automatic test_reset_midsend();
    logic [31:0] v;
    int n;
    mode = 0;
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) bus_write(TXD, 32'hA0 + i);
    mode = 3;
    n = en_cnt;
    force_busy = 1'b0;
    for (int i = 0; i < 50 && en_cnt == n; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    bus_read(CON, v);
    tests++; if (en_cnt != n + 1 || v[3] !== 1'b0 || tx_status !== 1'b0) begin
      fails++; $display("FAIL midsend_setup: launches %0d idle %b expected 1 0", en_cnt - n, v[3]);
    end
    rst = 1'b1;
    #1;
    tests++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin
      fails++; $display("FAIL midsend_rst_out: tx_en %b tx_data %h expected 0 00", tx_en, tx_data);
    end
    bus_read(CON, v);
    tests++; if (v !== 32'h8) begin fails++; $display("FAIL midsend_rst_con: got %h expected 00000008", v); end
    rst = 1'b0;
    n = en_cnt;
    mode = 0;
    repeat (40) @(negedge clk);
    bus_read(CON, v);
    tests++; if (en_cnt != n || v !== 32'h8) begin
      fails++; $display("FAIL midsend_after: launches %0d con %h expected 0 00000008", en_cnt - n, v);
    end
  endtask

  initial begin : main
    test_reset();
    test_single_tx();
    test_back_to_back();
    test_overflow();
    test_tx_irq();
    test_rx_basic();
    test_rx_overflow();
    test_rx_random();
    test_timeout();
    test_reset_midsend();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
